// File: rtl/md5_search_pkg.sv
// md5_search_pkg: MD5 salts, round constants, FSM encoding and step helpers
// shared by the search engine and the single-shot digest block.
package md5_search_pkg;

    localparam logic [31:0] SALT_A = 32'h67452301;
    localparam logic [31:0] SALT_B = 32'hefcdab89;
    localparam logic [31:0] SALT_C = 32'h98badcfe;
    localparam logic [31:0] SALT_D = 32'h10325476;

    localparam int MD5_STEPS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HASH,
        CHECK,
        DONE
    } md5_fsm_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } md5_abcd_t;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts repeat every four steps within a round.
    localparam logic [4:0] MD5_S [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] md5_k(input logic [5:0] step);
        return MD5_K[step];
    endfunction

    function automatic logic [4:0] md5_s(input logic [5:0] step);
        return MD5_S[{step[5:4], step[1:0]}];
    endfunction

    // Message word index; 4-bit arithmetic gives the mod-16 wrap.
    function automatic logic [3:0] md5_g(input logic [5:0] step);
        logic [3:0] p;
        p = step[3:0];
        case (step[5:4])
            2'd0:    return p;
            2'd1:    return p * 4'd5 + 4'd1;
            2'd2:    return p * 4'd3 + 4'd5;
            default: return p * 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/md5_operation.sv
// md5_operation: one combinational MD5 compression step, selected by
// {round, phase}; word 0 of the message sits in bits [511:480].
module md5_operation
    import md5_search_pkg::*;
(
    input  logic [1:0]   round_i,
    input  logic [3:0]   phase_i,
    input  md5_abcd_t    state_i,
    input  logic [511:0] msg_i,
    output md5_abcd_t    next_state_o
);

    logic [5:0]  step;
    logic [3:0]  g;
    logic [4:0]  s;
    logic [31:0] f;
    logic [31:0] m;
    logic [31:0] sum;
    logic [63:0] rot;

    assign step = {round_i, phase_i};
    assign g    = md5_g(step);
    assign s    = md5_s(step);
    assign m    = msg_i[{4'd15 - g, 5'd0} +: 32];

    always_comb begin
        f = '0;
        case (round_i)
            2'd0: f = (state_i.b & state_i.c) | (~state_i.b & state_i.d);
            2'd1: f = (state_i.d & state_i.b) | (~state_i.d & state_i.c);
            2'd2: f = state_i.b ^ state_i.c ^ state_i.d;
            default: f = state_i.c ^ (state_i.b | ~state_i.d);
        endcase
    end

    assign sum = state_i.a + f + md5_k(step) + m;
    // Upper half of the doubled word shifted left is the left rotate.
    assign rot = {sum, sum} << s;

    always_comb begin
        next_state_o.a = state_i.d;
        next_state_o.b = state_i.b + rot[63:32];
        next_state_o.c = state_i.b;
        next_state_o.d = state_i.c;
    end

endmodule

// File: rtl/md5_search.sv
// md5_search: brute-force search for a 128-bit candidate whose MD5 digest
// equals a target, one candidate every 66 cycles.
module md5_search
    import md5_search_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             action,
    input  logic [127:0]     target_digest,
    input  logic [127:0]     seed,
    input  logic [CNT_W-1:0] limit,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [127:0]     match_data,
    output logic [CNT_W-1:0] tries
);

    md5_fsm_e         state_q, state_d;
    logic [127:0]     cand_q, cand_d;
    logic [127:0]     target_q, target_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [511:0]     msg_q, msg_d;
    md5_abcd_t        abcd_q, abcd_d;
    logic [5:0]       step_q, step_d;
    logic [CNT_W-1:0] tries_q, tries_d;
    logic             found_q, found_d;
    logic [127:0]     match_q, match_d;

    md5_abcd_t        op_next;
    logic [127:0]     digest;
    logic [CNT_W-1:0] tries_inc;

    md5_operation u_op (
        .round_i      (step_q[5:4]),
        .phase_i      (step_q[3:0]),
        .state_i      (abcd_q),
        .msg_i        (msg_q),
        .next_state_o (op_next)
    );

    assign digest = {abcd_q.a + SALT_A, abcd_q.b + SALT_B,
                     abcd_q.c + SALT_C, abcd_q.d + SALT_D};
    assign tries_inc = tries_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        target_d = target_q;
        limit_d  = limit_q;
        msg_d    = msg_q;
        abcd_d   = abcd_q;
        step_d   = step_q;
        tries_d  = tries_q;
        found_d  = found_q;
        match_d  = match_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start && action) begin
                    target_d = target_digest;
                    cand_d   = seed;
                    limit_d  = limit;
                    tries_d  = '0;
                    found_d  = 1'b0;
                    state_d  = (limit == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    msg_d   = {cand_q, 384'b0};
                    abcd_d  = {SALT_A, SALT_B, SALT_C, SALT_D};
                    step_d  = '0;
                    state_d = HASH;
                end
            end
            HASH: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    abcd_d = op_next;
                    step_d = step_q + 6'd1;
                    if (step_q == 6'(MD5_STEPS - 1)) state_d = CHECK;
                end
            end
            CHECK: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    tries_d = tries_inc;
                    if (digest == target_q) begin
                        found_d = 1'b1;
                        match_d = cand_q;
                        state_d = DONE;
                    end else if (tries_inc == limit_q) begin
                        state_d = DONE;
                    end else begin
                        cand_d  = cand_q + 128'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            target_q <= '0;
            limit_q  <= '0;
            msg_q    <= '0;
            abcd_q   <= '0;
            step_q   <= '0;
            tries_q  <= '0;
            found_q  <= 1'b0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            target_q <= target_d;
            limit_q  <= limit_d;
            msg_q    <= msg_d;
            abcd_q   <= abcd_d;
            step_q   <= step_d;
            tries_q  <= tries_d;
            found_q  <= found_d;
            match_q  <= match_d;
        end
    end

    assign busy       = (state_q == LOAD) || (state_q == HASH) ||
                        (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign found      = found_q;
    assign match_data = match_q;
    assign tries      = tries_q;

endmodule

// File: tb/tb_md5_search.sv
// tb_md5_search: directed and randomized searches against a reference MD5
// model whose round constants are derived from sin() at run time.
module tb_md5_search;

    localparam int CNT_W = 32;
    localparam logic [31:0] IV [4] = '{
        32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476
    };
    localparam int SH [4][4] = '{
        '{7, 12, 17, 22}, '{5, 9, 14, 20},
        '{4, 11, 16, 23}, '{6, 10, 15, 21}
    };

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             action = 1'b0;
    logic [127:0]     target_digest = '0;
    logic [127:0]     seed = '0;
    logic [CNT_W-1:0] limit = '0;
    logic             busy;
    logic             done;
    logic             found;
    logic [127:0]     match_data;
    logic [CNT_W-1:0] tries;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md5_search #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .action        (action),
        .target_digest (target_digest),
        .seed          (seed),
        .limit         (limit),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .match_data    (match_data),
        .tries         (tries)
    );

    function automatic logic [127:0] md5_ref(input logic [127:0] data);
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, t, x, k;
        int          g, s;
        real         r;
        for (int i = 0; i < 16; i++) begin
            w[i] = 32'h0;
            if (i < 4) w[i] = data[127 - 32 * i -: 32];
        end
        a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            s = SH[i / 16][i % 4];
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            k = 32'(longint'($floor(r * 4294967296.0)));
            x = a + f + k + w[g];
            t = d; d = c; c = b;
            b = b + ((x << s) | (x >> (32 - s)));
            a = t;
        end
        return {a + IV[0], b + IV[1], c + IV[2], d + IV[3]};
    endfunction

    function automatic void ref_search(
        input  logic [127:0] tgt, sd,
        input  logic [31:0]  lim,
        output bit           fnd,
        output logic [127:0] md,
        output logic [31:0]  tr
    );
        logic [127:0] cand;
        fnd = 1'b0; md = '0; tr = '0; cand = sd;
        if (lim == 0) return;
        for (int n = 0; n < 1000; n++) begin
            tr = tr + 1;
            if (md5_ref(cand) == tgt) begin
                fnd = 1'b1; md = cand; return;
            end
            if (tr == lim) return;
            cand = cand + 128'd1;
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [127:0] tgt, sd, input logic [31:0] lim);
        tick();
        target_digest = tgt; seed = sd; limit = lim;
        start = 1'b1; action = 1'b1;
        tick();
        action = 1'b0;
    endtask

    task automatic run(input string tag, input logic [127:0] tgt, sd,
                       input logic [31:0] lim, input int pulse_at);
        bit           efound, busy_bad, hold_bad;
        logic [127:0] ematch;
        logic [31:0]  etries;
        int           cyc;
        ref_search(tgt, sd, lim, efound, ematch, etries);
        launch(tgt, sd, lim);
        cyc = 0; busy_bad = 0;
        while (!done && cyc < 700) begin
            if (busy !== 1'b1) busy_bad = 1;
            if (cyc == pulse_at) begin
                action = 1'b1; seed = ~sd; limit = '0;
            end
            tick();
            cyc++;
            action = 1'b0; seed = sd; limit = lim;
        end
        chk({tag, "_cycle"}, 128'(cyc), 128'(66 * etries));
        chk({tag, "_busy_run"}, 128'(busy_bad), 128'(0));
        chk({tag, "_found"}, 128'(found), 128'(efound));
        chk({tag, "_tries"}, 128'(tries), 128'(etries));
        if (efound) chk({tag, "_match"}, match_data, ematch);
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b1 || busy !== 1'b0) hold_bad = 1;
            tick();
        end
        chk({tag, "_hold"}, 128'(hold_bad), 128'(0));
    endtask

    initial begin
        logic [127:0] sd, sd2, tgt;
        logic [31:0]  lim;

        repeat (2) tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_found", 128'(found), 128'(0));
        chk("rst_tries", 128'(tries), 128'(0));
        chk("rst_match", match_data, 128'(0));
        rst = 1'b1;
        tick();

        run("hit3", md5_ref(128'h3), 128'h0, 32'd10, 70);
        run("miss", md5_ref(128'h5), 128'h6, 32'd3, -1);
        run("lim0", {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 32'd0, -1);
        run("wrap", md5_ref(128'h0), {128{1'b1}}, 32'd2, -1);

        for (int i = 0; i < 3; i++) begin
            sd  = {$urandom, $urandom, $urandom, $urandom};
            tgt = md5_ref(sd + 128'($urandom_range(0, 4)));
            lim = 32'($urandom_range(1, 4));
            run($sformatf("rnd%0d", i), tgt, sd, lim, 40);
        end

        sd = {$urandom, $urandom, $urandom, $urandom};
        launch(md5_ref(sd + 128'd5), sd, 32'd10);
        repeat (29) tick();
        chk("abort_busy_before", 128'(busy), 128'(1));
        start = 1'b0;
        tick();
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_tries", 128'(tries), 128'(0));
        repeat (3) tick();
        chk("abort_done_later", 128'(done), 128'(0));
        sd2 = {$urandom, $urandom, $urandom, $urandom};
        run("relaunch", md5_ref(sd2 + 128'd1), sd2, 32'd5, -1);

        sd = {$urandom, $urandom, $urandom, $urandom};
        launch(md5_ref(sd + 128'd2), sd, 32'd5);
        repeat (39) tick();
        action = 1'b1; seed = ~sd; limit = '0;
        tick();
        action = 1'b0; seed = sd; limit = 32'd5;
        chk("ignore_busy", 128'(busy), 128'(1));
        chk("ignore_done", 128'(done), 128'(0));
        repeat (60) tick();
        chk("pre_rst_tries", 128'(tries), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_found", 128'(found), 128'(0));
        chk("arst_tries", 128'(tries), 128'(0));
        chk("arst_match", match_data, 128'(0));
        action = 1'b1;
        repeat (2) tick();
        chk("in_rst_busy", 128'(busy), 128'(0));
        action = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", 128'(busy), 128'(0));
        chk("post_rst_done", 128'(done), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
